// File: rtl/deco_pkg.sv
// deco_pkg: shared types and constants for the turbo decoder frame loader.
//   deco_state_e   loader FSM states
//   DECO_*         default beat width, beats per frame and result width
//   clog2()        counter width helper (never returns less than 1)
package deco_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } deco_state_e;

    localparam int unsigned DECO_BEAT_W = 21;
    localparam int unsigned DECO_BEATS  = 4;
    localparam int unsigned DECO_OUT_W  = 5;

    // Minimum of 1 bit so a one-value counter still has a legal width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/deco_beat_shift.sv
// deco_beat_shift: shadow register that assembles one frame from beats.
//   clk, rst_n   clock / async active-low reset
//   first        beat 0 strobe; beat order is taken from msb_first and latched
//   load         capture data into the slot selected by beat_idx and order
//   beat_idx     index of the beat presented on data
//   msb_first    order select (0: beat k in slot k, 1: beat k in slot BEATS-1-k)
//   data         beat value
//   shadow_nxt   shadow contents including the beat being captured this cycle
module deco_beat_shift
    import deco_pkg::*;
#(
    parameter int unsigned BEAT_W = DECO_BEAT_W,
    parameter int unsigned BEATS  = DECO_BEATS,
    parameter int unsigned BCW    = clog2(BEATS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    first,
    input  logic                    load,
    input  logic [BCW-1:0]          beat_idx,
    input  logic                    msb_first,
    input  logic [BEAT_W-1:0]       data,
    output logic [BEATS*BEAT_W-1:0] shadow_nxt
);

    localparam logic [BCW-1:0] LAST_SLOT = BCW'(BEATS - 1);

    logic [BEATS*BEAT_W-1:0] shadow_q;
    logic                    msb_q;
    logic                    order;
    logic [BCW-1:0]          slot;

    // Beat 0 uses the live order input; later beats use the latched copy.
    assign order = first ? msb_first : msb_q;
    assign slot  = order ? (LAST_SLOT - beat_idx) : beat_idx;

    // Exposing the next value lets the top load frame_o in the same cycle
    // the last beat arrives.
    always_comb begin
        shadow_nxt = shadow_q;
        if (load) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (slot == BCW'(k)) shadow_nxt[k*BEAT_W +: BEAT_W] = data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            msb_q    <= 1'b0;
        end else begin
            if (load)  shadow_q <= shadow_nxt;
            if (first) msb_q    <= msb_first;
        end
    end

endmodule

// File: rtl/deco_frame_loader.sv
// deco_frame_loader: deserialises BEATS beats into a frame, hands it to the
// turbo decoder core over valid/ready, and captures the decoder result.
//   clk_p_i, reset_n_i        clock / async active-low reset
//   start_i, data_i           beat bus; a frame begins on the rising edge of start_i
//   msb_first_i               beat order, sampled with beat 0
//   frame_o, frame_valid_o    assembled frame, held until dec_ready_i
//   dec_ready_i               decoder accepts frame_o
//   dec_done_i, dec_data_i    decoder result pulse and value
//   data_o, done_o            last result and its one-cycle update pulse
//   busy_o                    high outside IDLE
//   abort_o, timeout_o        short-frame and decoder-timeout pulses
//   frame_cnt_o               completed frames, wrapping
module deco_frame_loader
    import deco_pkg::*;
#(
    parameter int unsigned BEAT_W  = DECO_BEAT_W,
    parameter int unsigned BEATS   = DECO_BEATS,
    parameter int unsigned OUT_W   = DECO_OUT_W,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk_p_i,
    input  logic                    reset_n_i,
    input  logic                    start_i,
    input  logic [BEAT_W-1:0]       data_i,
    input  logic                    msb_first_i,
    output logic [BEATS*BEAT_W-1:0] frame_o,
    output logic                    frame_valid_o,
    input  logic                    dec_ready_i,
    input  logic                    dec_done_i,
    input  logic [OUT_W-1:0]        dec_data_i,
    output logic [OUT_W-1:0]        data_o,
    output logic                    done_o,
    output logic                    busy_o,
    output logic                    abort_o,
    output logic                    timeout_o,
    output logic [CNT_W-1:0]        frame_cnt_o
);

    localparam int unsigned    BCW       = clog2(BEATS);
    localparam int unsigned    TW        = clog2(TIMEOUT);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT - 1);

    deco_state_e             state;
    logic                    start_q;
    logic [BCW-1:0]          beat_cnt;
    logic [TW-1:0]           to_cnt;
    logic                    start_rise;
    logic                    first_beat;
    logic                    capture;
    logic [BCW-1:0]          beat_idx;
    logic [BEATS*BEAT_W-1:0] shadow_nxt;

    assign start_rise = start_i & ~start_q;
    assign first_beat = (state == IDLE) & start_rise;
    assign capture    = first_beat | ((state == LOAD) & start_i);
    assign beat_idx   = first_beat ? '0 : beat_cnt;

    deco_beat_shift #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS),
        .BCW    (BCW)
    ) u_shift (
        .clk        (clk_p_i),
        .rst_n      (reset_n_i),
        .first      (first_beat),
        .load       (capture),
        .beat_idx   (beat_idx),
        .msb_first  (msb_first_i),
        .data       (data_i),
        .shadow_nxt (shadow_nxt)
    );

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= IDLE;
            // Reset high so a start_i already asserted at release is not an edge.
            start_q       <= 1'b1;
            beat_cnt      <= '0;
            to_cnt        <= '0;
            frame_o       <= '0;
            frame_valid_o <= 1'b0;
            data_o        <= '0;
            done_o        <= 1'b0;
            busy_o        <= 1'b0;
            abort_o       <= 1'b0;
            timeout_o     <= 1'b0;
            frame_cnt_o   <= '0;
        end else begin
            start_q   <= start_i;
            done_o    <= 1'b0;
            abort_o   <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        busy_o <= 1'b1;
                        if (BEATS == 1) begin
                            frame_o       <= shadow_nxt;
                            frame_valid_o <= 1'b1;
                            state         <= ISSUE;
                        end else begin
                            beat_cnt <= BCW'(1);
                            state    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (start_i) begin
                        if (beat_cnt == LAST_BEAT) begin
                            frame_o       <= shadow_nxt;
                            frame_valid_o <= 1'b1;
                            state         <= ISSUE;
                        end else begin
                            beat_cnt <= beat_cnt + BCW'(1);
                        end
                    end else begin
                        abort_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ISSUE: begin
                    if (dec_ready_i) begin
                        frame_valid_o <= 1'b0;
                        to_cnt        <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // A result on the last allowed cycle still counts as done.
                    if (dec_done_i) begin
                        data_o      <= dec_data_i;
                        done_o      <= 1'b1;
                        frame_cnt_o <= frame_cnt_o + CNT_W'(1);
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/deco_frame_loader.md
Name: deco_frame_loader

Overview:
- Parametrised front-end for the turbo decoder core.
- Deserialises a frame of BEATS input beats, each BEAT_W bits wide, arriving on a start-qualified bus.
- Hands the assembled frame to the decoder core over a valid/ready handshake, then captures the decoder result and presents it with a one-cycle done pulse.
- Adds behaviour the fixed 4x21-bit loader lacks: configurable beat order, abort on short frames, decoder timeout, and a frame counter.

Parameters:
- BEAT_W, 21, width of one input beat in bits.
- BEATS, 4, number of beats per frame (2..16).
- OUT_W, 5, width of the decoded result.
- TIMEOUT, 1024, maximum cycles to wait for dec_done_i after handoff (>=2).
- CNT_W, 16, width of the frame counter.

Ports:
- clk_p_i  in  1  clock; all logic on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  high while beats are presented; a frame begins on its rising edge.
- data_i  in  BEAT_W  input beat, valid in every cycle start_i=1 during LOAD.
- msb_first_i  in  1  beat order select; sampled together with beat 0.
- frame_o  out  BEATS*BEAT_W  assembled frame to the decoder core.
- frame_valid_o  out  1  frame_o valid, held until accepted.
- dec_ready_i  in  1  decoder core accepts frame_o.
- dec_done_i  in  1  decoder core result valid (single-cycle pulse).
- dec_data_i  in  OUT_W  decoder core result.
- data_o  out  OUT_W  registered result of the last completed frame.
- done_o  out  1  one-cycle pulse; data_o is updated in the same cycle.
- busy_o  out  1  high in every state except IDLE.
- abort_o  out  1  one-cycle pulse when a frame is cut short.
- timeout_o  out  1  one-cycle pulse when the decoder does not answer in time.
- frame_cnt_o  out  CNT_W  number of completed frames; wraps at 2^CNT_W.

Behaviour:
Reset:
- All outputs go to 0 asynchronously: frame_o, data_o, frame_cnt_o and all flags.
- The FSM enters IDLE.
- The start_i edge register resets to 1, so a start_i already high when reset is released does not begin a frame.

FSM states: IDLE, LOAD, ISSUE, WAIT.
- IDLE:
  - A rising edge of start_i (start_i=1 and previous-cycle start_i=0) captures data_i as beat 0 and latches msb_first_i.
  - The beat counter becomes 1 and the FSM goes to LOAD.
  - If BEATS=1 it goes directly to ISSUE.
- LOAD:
  - Each cycle with start_i=1 captures the next beat and increments the counter.
  - After beat BEATS-1 is captured, the FSM goes to ISSUE with frame_valid_o=1 in the next cycle.
  - If start_i=0 before the last beat: abort_o pulses, the partial frame is discarded, frame_o is unchanged, and the FSM returns to IDLE.
- Beat placement:
  - msb_first=0: beat k goes to bits [(k+1)*BEAT_W-1 : k*BEAT_W].
  - msb_first=1: beat k goes to slot BEATS-1-k.
  - Beats assemble in a shadow register; frame_o loads only on the LOAD->ISSUE transition.
- ISSUE:
  - frame_valid_o=1 and frame_o is stable.
  - When dec_ready_i=1, frame_valid_o drops the next cycle and the FSM goes to WAIT with the timeout counter cleared.
- WAIT:
  - On dec_done_i=1: data_o<=dec_data_i, done_o pulses, frame_cnt_o increments, and the FSM goes to IDLE.
  - If the counter reaches TIMEOUT-1 without dec_done_i: timeout_o pulses, data_o and frame_cnt_o are unchanged, and the FSM goes to IDLE.
  - If dec_done_i arrives in the same cycle the counter reaches TIMEOUT-1, done wins and timeout_o stays 0.
- start_i outside IDLE/LOAD:
  - It is ignored, including extra start_i-high cycles after the last beat.
  - A new frame needs start_i low for at least one cycle, then a rising edge, which is only honoured in IDLE.
- dec_done_i outside WAIT is ignored.
- Latency: last beat to frame_valid_o is 1 cycle; dec_done_i to done_o/data_o is 1 cycle.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0; a partial frame is never issued.

Decomposition:
- Package deco_pkg:
  - FSM state enum (IDLE, LOAD, ISSUE, WAIT).
  - Default constants DECO_BEAT_W=21, DECO_BEATS=4, DECO_OUT_W=5.
  - Beat counter width function clog2(BEATS).
- One natural sub-module: deco_beat_shift, the beat assembly register with order select and load strobe.
- The FSM, timeout counter and frame counter stay in the top level.

Test Plan:
- Normal frame, defaults, msb_first=0:
  - Stimulus: beats 0x00001, 0x00002, 0x00003, 0x00004 with start held for 5 cycles; dec_ready_i=1; dec_done_i 3 cycles later with dec_data_i=5'b10110.
  - Response: frame_o=0x00004_00003_00002_00001 (21-bit slots), done_o pulses once, data_o=10110, frame_cnt_o=1.
- Same beats with msb_first=1 -> frame_o has beat 0 in the top slot and beat 3 in the bottom slot.
- start_i dropped after 2 beats -> abort_o pulses one cycle, frame_valid_o stays 0, frame_o keeps its previous value, FSM back in IDLE.
- dec_ready_i held 0 for 7 cycles -> frame_valid_o and frame_o stay stable for 7 cycles; handoff on cycle 8.
- TIMEOUT=16 and no dec_done_i:
  - timeout_o pulses 16 cycles after handoff, data_o unchanged, frame_cnt_o unchanged.
  - dec_done_i on the final cycle -> done_o=1 and timeout_o=0.
- Reset asserted while in LOAD after beat 2 -> all outputs 0 immediately; the next full frame completes with frame_cnt_o=1.
